// File: rtl/nn_sched_pkg.sv
// -----------------------------------------------------------------------------
// nn_sched_pkg
// Shared definitions for the NN inference arbiter slice.
//   - State encoding of the request/response FSM.
//   - Default sample width, result width and RUN-phase timeout.
// -----------------------------------------------------------------------------
package nn_sched_pkg;

  localparam int NN_DATA_W  = 496;   // 62 x 8-bit pixels
  localparam int NN_RES_W   = 4;     // class index width
  localparam int NN_TIMEOUT = 1023;  // max RUN cycles before abort

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } nn_state_t;

endpackage : nn_sched_pkg

// File: rtl/nn_rr_arb2.sv
// -----------------------------------------------------------------------------
// nn_rr_arb2
// Two-way round-robin grant selection (purely combinational).
// Ports:
//   valid[1:0] in  : request flags of requester 1 / 0
//   last       in  : id of the requester served most recently
//   grant      out : id of the winning requester (meaningful when any=1)
//   any        out : at least one requester is valid
// -----------------------------------------------------------------------------
module nn_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  assign any = |valid;

  // On contention the requester that was not served last wins; otherwise
  // the single valid requester (or 0 when idle, which is don't-care).
  always_comb begin
    if (valid == 2'b11) begin
      grant = ~last;
    end else begin
      grant = valid[1];
    end
  end

endmodule : nn_rr_arb2

// File: rtl/nn_inference_arbiter.sv
// -----------------------------------------------------------------------------
// nn_inference_arbiter
// Shares one neural-network inference engine between two requesters. One
// inference is in flight at a time: accept a sample, pulse nn_start, wait for
// nn_finish (or abort after TIMEOUT RUN cycles), then hold the result for the
// granted requester until it is consumed.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   reqN_valid/ready/data (N=0,1)   : sample request handshake
//   resN_valid/ready/result/timeout : result handshake per requester
//   nn_start, nn_input_data         : engine start pulse and sample feed
//   nn_finish, nn_result            : engine completion flag and class index
//   busy                            : FSM is not in IDLE
// -----------------------------------------------------------------------------
module nn_inference_arbiter
  import nn_sched_pkg::*;
#(
  parameter int DATA_W  = NN_DATA_W,
  parameter int RES_W   = NN_RES_W,
  parameter int TIMEOUT = NN_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  output logic              res0_valid,
  input  logic              res0_ready,
  output logic [RES_W-1:0]  res0_result,
  output logic              res0_timeout,
  output logic              res1_valid,
  input  logic              res1_ready,
  output logic [RES_W-1:0]  res1_result,
  output logic              res1_timeout,
  output logic              nn_start,
  output logic [DATA_W-1:0] nn_input_data,
  input  logic              nn_finish,
  input  logic [RES_W-1:0]  nn_result,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  nn_state_t          state_reg;
  logic [DATA_W-1:0]  hold_reg;
  logic [RES_W-1:0]   result_reg;
  logic               timeout_reg;
  logic               grant_reg;
  logic               last_reg;
  logic               nn_start_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               arb_grant;
  logic               arb_any;
  logic               in_idle;
  logic               in_resp;
  logic               accept;
  logic               res_ack;

  nn_rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last_reg),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign in_idle = (state_reg == ST_IDLE);
  assign in_resp = (state_reg == ST_RESP);

  // Ready is gated by rst so nothing is offered while reset is held, even
  // though the FSM already sits in IDLE.
  assign req0_ready = rst & in_idle & arb_any & ~arb_grant & req0_valid;
  assign req1_ready = rst & in_idle & arb_any &  arb_grant & req1_valid;
  assign accept     = req0_ready | req1_ready;

  assign res_ack    = grant_reg ? res1_ready : res0_ready;

  assign res0_valid   = in_resp & ~grant_reg;
  assign res1_valid   = in_resp &  grant_reg;
  assign res0_result  = res0_valid ? result_reg : '0;
  assign res1_result  = res1_valid ? result_reg : '0;
  assign res0_timeout = res0_valid & timeout_reg;
  assign res1_timeout = res1_valid & timeout_reg;

  assign nn_start      = nn_start_reg;
  assign nn_input_data = hold_reg;
  assign busy          = ~in_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      hold_reg     <= '0;
      result_reg   <= '0;
      timeout_reg  <= 1'b0;
      grant_reg    <= 1'b0;
      last_reg     <= 1'b1;   // requester 0 wins the first contention
      nn_start_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            hold_reg     <= arb_grant ? req1_data : req0_data;
            grant_reg    <= arb_grant;
            nn_start_reg <= 1'b1;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          nn_start_reg <= 1'b0;
          cnt_reg      <= '0;
          state_reg    <= ST_RUN;
        end
        ST_RUN: begin
          // A finish arriving on the final allowed cycle beats the abort.
          if (nn_finish) begin
            result_reg  <= nn_result;
            timeout_reg <= 1'b0;
            state_reg   <= ST_RESP;
          end else if (cnt_reg == CNT_LAST) begin
            result_reg  <= '0;
            timeout_reg <= 1'b1;
            state_reg   <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (res_ack) begin
            last_reg  <= grant_reg;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule : nn_inference_arbiter

// File: tb/tb_nn_inference_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nn_inference_arbiter
// Directed, table-driven bench for nn_inference_arbiter. Each table row is one
// complete transaction (request, engine run, response); reset behaviour is
// covered by short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_nn_inference_arbiter;

  localparam int DW = 496;
  localparam int RW = 4;
  localparam int TO = 1023;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_data, req1_data;
  logic          res0_valid, res1_valid;
  logic          res0_ready, res1_ready;
  logic [RW-1:0] res0_result, res1_result;
  logic          res0_timeout, res1_timeout;
  logic          nn_start;
  logic [DW-1:0] nn_input_data;
  logic          nn_finish;
  logic [RW-1:0] nn_result;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nn_inference_arbiter #(
    .DATA_W  (DW),
    .RES_W   (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_data     (req1_data),
    .res0_valid    (res0_valid),
    .res0_ready    (res0_ready),
    .res0_result   (res0_result),
    .res0_timeout  (res0_timeout),
    .res1_valid    (res1_valid),
    .res1_ready    (res1_ready),
    .res1_result   (res1_result),
    .res1_timeout  (res1_timeout),
    .nn_start      (nn_start),
    .nn_input_data (nn_input_data),
    .nn_finish     (nn_finish),
    .nn_result     (nn_result),
    .busy          (busy)
  );

  typedef struct {
    logic          v0;
    logic          v1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int            n_run;      // RUN cycle carrying nn_finish; 0 = never
    logic [RW-1:0] nres;
    int            exp_g;
    logic [RW-1:0] exp_res;
    logic          exp_to;
    int            hold;       // cycles the result is left unconsumed
    logic          stray_fin;  // pulse nn_finish in IDLE and START first
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic v1, input int n_run,
                              input int nres, input int exp_g, input int exp_res,
                              input logic exp_to, input int hold, input logic stray,
                              input int seed);
    vec_t v;
    logic [15:0] p0;
    logic [15:0] p1;
    p0 = 16'hA000 + 16'(seed);
    p1 = 16'h5000 + 16'(seed);
    v.v0 = v0;
    v.v1 = v1;
    v.d0 = {31{p0}};
    v.d1 = {31{p1}};
    v.n_run = n_run;
    v.nres = RW'(nres);
    v.exp_g = exp_g;
    v.exp_res = RW'(exp_res);
    v.exp_to = exp_to;
    v.hold = hold;
    v.stray_fin = stray;
    return v;
  endfunction

  // Runs one transaction; entered and left just after a falling edge.
  task automatic do_txn(input vec_t v, input int idx);
    logic [DW-1:0] exp_data;
    logic [RW-1:0] win_res;
    logic          win_to;
    int            lat, exp_lat, starts, bad_rdy, stable_bad;
    bit            got, done;
    string         tag;
    tag = $sformatf("v%0d", idx);
    exp_data = (v.exp_g != 0) ? v.d1 : v.d0;

    if (v.stray_fin) begin
      nn_finish = 1'b1;
      nn_result = RW'(14);
      @(negedge clk);
      nn_finish = 1'b0;
      #1;
      check({tag, "_idle_fin_busy"}, 64'(busy), 64'(0));
      check({tag, "_idle_fin_resv"}, 64'({res1_valid, res0_valid}), 64'(0));
    end

    req0_data  = v.d0;
    req1_data  = v.d1;
    req0_valid = v.v0;
    req1_valid = v.v1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_accept"}, 64'(got), 64'(1));
    if (!got) return;
    check({tag, "_grant"}, 64'({req1_ready, req0_ready}),
          64'((v.exp_g != 0) ? 2'b10 : 2'b01));

    // START cycle
    @(negedge clk);
    if (v.exp_g != 0) req1_valid = 1'b0;
    else              req0_valid = 1'b0;
    nn_finish = v.stray_fin;
    nn_result = RW'(13);
    #1;
    check({tag, "_start_pulse"}, 64'(nn_start), 64'(1));
    check_d({tag, "_start_data"}, nn_input_data, exp_data);

    starts  = 0;
    bad_rdy = 0;
    done    = 0;
    exp_lat = (v.n_run > 0) ? v.n_run + 2 : TO + 2;
    for (lat = 2; lat < TO + 20; lat++) begin
      @(negedge clk);
      nn_finish = 1'b0;
      if (nn_start) starts++;
      if (req0_ready || req1_ready) bad_rdy++;
      if (res0_valid || res1_valid) begin
        done = 1;
        break;
      end
      if (lat - 1 == v.n_run) begin
        nn_finish = 1'b1;
        nn_result = v.nres;
      end
    end
    check({tag, "_resp_seen"}, 64'(done), 64'(1));
    if (!done) return;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_single_start"}, 64'(starts), 64'(0));
    check({tag, "_ready_busy"}, 64'(bad_rdy), 64'(0));
    check({tag, "_resv"}, 64'({res1_valid, res0_valid}),
          64'((v.exp_g != 0) ? 2'b10 : 2'b01));
    win_res = (v.exp_g != 0) ? res1_result : res0_result;
    win_to  = (v.exp_g != 0) ? res1_timeout : res0_timeout;
    check({tag, "_result"}, 64'(win_res), 64'(v.exp_res));
    check({tag, "_timeout"}, 64'(win_to), 64'(v.exp_to));
    check_d({tag, "_data_hold"}, nn_input_data, exp_data);

    if (v.hold > 0) begin
      stable_bad = 0;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        if ({res1_valid, res0_valid} !== ((v.exp_g != 0) ? 2'b10 : 2'b01)) stable_bad++;
        if (((v.exp_g != 0) ? res1_result : res0_result) !== v.exp_res) stable_bad++;
        if (req0_ready || req1_ready) stable_bad++;
      end
      check({tag, "_hold_stable"}, 64'(stable_bad), 64'(0));
    end

    if (v.exp_g != 0) res1_ready = 1'b1;
    else              res0_ready = 1'b1;
    @(negedge clk);
    res0_ready = 1'b0;
    res1_ready = 1'b0;
    #1;
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check({tag, "_idle_resv"}, 64'({res1_valid, res0_valid}), 64'(0));
    // Only the loser can still be valid; it must be offered straight away.
    check({tag, "_next_ready"}, 64'({req1_ready, req0_ready}),
          64'({req1_valid, req0_valid}));
    $display("txn %0d grant=%0d result=%0h timeout=%0b latency=%0d",
             idx, v.exp_g, win_res, win_to, lat);
  endtask

  initial begin
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    res0_ready = 1'b0;
    res1_ready = 1'b0;
    nn_finish  = 1'b0;
    nn_result  = '0;

    //           v0 v1 n_run nres g  res to hold stray seed
    vecs[0] = mk(1, 1, 3,    2,   0, 2,  0, 0,   0,    0);  // contention from reset -> req0
    vecs[1] = mk(1, 1, 2,    5,   1, 5,  0, 0,   0,    1);  // alternation -> req1
    vecs[2] = mk(1, 1, 4,    3,   0, 3,  0, 10,  0,    2);  // req0 again, result held 10 cycles
    vecs[3] = mk(0, 1, 1,    15,  1, 15, 0, 0,   0,    3);  // pending req1 taken next cycle
    vecs[4] = mk(1, 0, 5,    7,   0, 7,  0, 0,   0,    4);  // latency 7, result 7
    vecs[5] = mk(0, 1, 0,    9,   1, 0,  1, 0,   0,    5);  // never finishes -> timeout
    vecs[6] = mk(1, 0, TO,   6,   0, 6,  0, 0,   0,    6);  // finish on final cycle wins
    vecs[7] = mk(1, 0, 4,    11,  0, 11, 0, 0,   1,    7);  // stray finish in IDLE/START

    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check("reset_ready", 64'({req1_ready, req0_ready}), 64'(0));
    check("reset_outs", 64'({busy, nn_start, res0_valid, res1_valid,
                             res0_timeout, res1_timeout}), 64'(0));
    check("reset_results", 64'({res1_result, res0_result}), 64'(0));
    check_d("reset_data", nn_input_data, '0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i], i);
    end

    // Reset in the middle of RUN drops the inference silently.
    @(negedge clk);
    req0_data  = {31{16'h1234}};
    req0_valid = 1'b1;
    #1;
    check("mr_accept", 64'(req0_ready), 64'(1));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = {31{16'h4321}};
    repeat (3) @(negedge clk);
    check("mr_busy_run", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    check("mr_outs", 64'({busy, nn_start, req0_ready, req1_ready, res0_valid,
                          res1_valid, res0_timeout, res1_timeout}), 64'(0));
    check_d("mr_data", nn_input_data, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_req1_ready", 64'({req1_ready, req0_ready}), 64'(2'b10));
    do_txn(mk(0, 1, 2, 4, 1, 4, 0, 0, 0, 8), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nn_inference_arbiter
